// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// ALUOp/ALUControl codes, datapath mux selects and the opcode-to-ImmSrc map.
package multicycle_ctrl_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // R-type and unknown opcodes have no immediate; I-format is the harmless default.
   function automatic logic [1:0] imm_src(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_BEQ:  return IMM_B;
         OP_JAL:  return IMM_J;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle datapath (master) and its
// controller (slave): instruction fields and status in, strobes and selects out.
interface multicycle_ctrl_if #(
   parameter int ALUCTRL_W = 3
);
   logic [6:0]           op;
   logic [2:0]           funct3;
   logic                 funct7b5;
   logic                 Zero;
   logic                 MemReady;

   logic                 PCWrite;
   logic                 AdrSrc;
   logic                 MemWrite;
   logic                 IRWrite;
   logic                 RegWrite;
   logic [1:0]           ResultSrc;
   logic [1:0]           ALUSrcA;
   logic [1:0]           ALUSrcB;
   logic [1:0]           ImmSrc;
   logic [ALUCTRL_W-1:0] ALUControl;

   modport master (
      output op, funct3, funct7b5, Zero, MemReady,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
   );

   modport slave (
      input  op, funct3, funct7b5, Zero, MemReady,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
   );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus funct fields onto ALUControl.
// Unsupported funct3 values decode to add so the output is never X.
module alu_decoder
   import multicycle_ctrl_pkg::*;
#(
   parameter int ALUCTRL_W = 3
) (
   input  aluop_t               aluop,
   input  logic [2:0]           funct3,
   input  logic                 op5,
   input  logic                 funct7b5,
   output logic [ALUCTRL_W-1:0] alucontrol
);

   logic [2:0] ctrl;

   always_comb begin
      ctrl = ALU_ADD;
      case (aluop)
         ALUOP_ADD: ctrl = ALU_ADD;
         ALUOP_SUB: ctrl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only R-type (op[5]=1) subtracts; addi with imm[10]=1 stays add.
               3'b000:  ctrl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  ctrl = ALU_SLT;
               3'b110:  ctrl = ALU_OR;
               3'b111:  ctrl = ALU_AND;
               default: ctrl = ALU_ADD;
            endcase
         end
         default: ctrl = ALU_ADD;
      endcase
   end

   assign alucontrol = ALUCTRL_W'(ctrl);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore multicycle RV32I controller (lw, sw, R, I-ALU, beq, jal) with MemReady stalls.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes and expose IllegalInstr.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int ALUCTRL_W = 3,
   parameter int STATE_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   multicycle_ctrl_if.slave   bus
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
   ,
   output logic               IllegalInstr
`endif
);

   logic [STATE_W-1:0] state_q;
   state_t             state;
   state_t             state_d;

   logic       pcupdate;
   logic       branch;
   aluop_t     aluop;
   logic       adrsrc;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic [1:0] resultsrc;
   logic [1:0] alusrca;
   logic [1:0] alusrcb;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
   logic       illegal;
`endif

   assign state = state_t'(state_q[$bits(state_t)-1:0]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= STATE_W'(S_FETCH);
      else       state_q <= STATE_W'(state_d);
   end

   always_comb begin
      state_d   = state;
      pcupdate  = 1'b0;
      branch    = 1'b0;
      aluop     = ALUOP_ADD;
      adrsrc    = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      regwrite  = 1'b0;
      resultsrc = RES_ALUOUT;
      alusrca   = SRCA_PC;
      alusrcb   = SRCB_RS2;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      illegal   = 1'b0;
`endif
      case (state)
         S_FETCH: begin
            alusrcb   = SRCB_FOUR;
            resultsrc = RES_ALURESULT;
            irwrite   = bus.MemReady;
            pcupdate  = bus.MemReady;
            if (bus.MemReady) state_d = S_DECODE;
         end
         S_DECODE: begin
            // OldPC + ImmExt lands in ALUOut as the speculative branch target.
            alusrca = SRCA_OLDPC;
            alusrcb = SRCB_IMM;
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
               default:      state_d = S_TRAP;
`else
               default:      state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_IMM;
            state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adrsrc = 1'b1;
            if (bus.MemReady) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            resultsrc = RES_DATA;
            regwrite  = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            adrsrc   = 1'b1;
            memwrite = 1'b1;
            if (bus.MemReady) state_d = S_FETCH;
         end
         S_EXECUTER: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_RS2;
            aluop   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_IMM;
            aluop   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            resultsrc = RES_ALUOUT;
            regwrite  = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_RS2;
            aluop   = ALUOP_SUB;
            branch  = 1'b1;
            state_d = S_FETCH;
         end
         S_JAL: begin
            // PC <= target from ALUOut while ALU forms OldPC+4 for the link write.
            alusrca  = SRCA_OLDPC;
            alusrcb  = SRCB_FOUR;
            pcupdate = 1'b1;
            state_d  = S_ALUWB;
         end
         S_TRAP: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            illegal = 1'b1;
`else
            state_d = S_FETCH;
`endif
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Write enables are gated by reset directly so an in-flight store drops at once.
   assign bus.PCWrite   = ~reset & (pcupdate | (branch & bus.Zero));
   assign bus.IRWrite   = ~reset & irwrite;
   assign bus.MemWrite  = ~reset & memwrite;
   assign bus.RegWrite  = ~reset & regwrite;
   assign bus.AdrSrc    = adrsrc;
   assign bus.ResultSrc = resultsrc;
   assign bus.ALUSrcA   = alusrca;
   assign bus.ALUSrcB   = alusrcb;
   assign bus.ImmSrc    = imm_src(bus.op);

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
   assign IllegalInstr = ~reset & illegal;
`endif

   alu_decoder #(
      .ALUCTRL_W (ALUCTRL_W)
   ) u_alu_decoder (
      .aluop      (aluop),
      .funct3     (bus.funct3),
      .op5        (bus.op[5]),
      .funct7b5   (bus.funct7b5),
      .alucontrol (bus.ALUControl)
   );

endmodule

// File: doc/multicycle_ctrl.md
Name:
multicycle_ctrl

Overview:
- Multicycle RV32I control unit that directly feeds the immediate extender in the control path.
- Contains a Moore main FSM, an ALU decoder and the instruction-type decoder that drives ImmSrc into the extender.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Memory accesses stall on a MemReady handshake.

Parameters:
- ALUCTRL_W, 3, width of ALUControl.
- STATE_W, 4, width of the FSM state register.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op  in  7  opcode, Instr[6:0], from the instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory has completed the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register (and OldPC) enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  to extender: 00=I, 01=S, 10=B, 11=J
- ALUControl  out  ALUCTRL_W  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt

Behaviour:
- State register:
  - Asynchronous reset forces FETCH.
  - Next state is taken on the rising edge of clk.
  - All outputs are combinational from state (Moore); ImmSrc and ALUControl also depend on op/funct fields.
- Reset values:
  - While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - All other outputs take their FETCH values: AdrSrc=0, ResultSrc=10, ALUSrcA=00, ALUSrcB=10.
- Unlisted outputs default to 0: AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, internal ALUOp=00, Branch, PCUpdate.
- PCWrite = PCUpdate | (Branch & Zero).
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite=MemReady, PCUpdate=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01 (branch target computed into ALUOut).
  - Next state: lw(0000011)/sw(0100011) -> MEMADR; R(0110011) -> EXECUTER; I(0010011) -> EXECUTEI; beq(1100011) -> BEQ; jal(1101111) -> JAL.
  - Any other op -> FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01. Goes to MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: AdrSrc=1. Goes to MEMWB when MemReady=1, else holds.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 (held until MemReady). Goes to FETCH when MemReady=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00. Goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1. Goes to FETCH; PC takes ALUOut only if Zero=1 in this cycle.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1. Goes to ALUWB (rd<=PC+4).
- ImmSrc is decoded from op only, independent of state:
  - lw and I-ALU -> 00; sw -> 01; beq -> 10; jal -> 11.
  - R-type and unknown op -> 00.
- ALU decoder:
  - ALUOp=00 -> add; ALUOp=01 -> sub.
  - ALUOp=10, decode by funct3:
    - 000: sub if (op[5] & funct7b5), else add.
    - 010: slt; 110: or; 111: and.
    - Any other funct3: add (never X).
- Latencies with MemReady=1:
  - lw: 5 cycles.
  - R-type, I-ALU, sw, jal: 4 cycles.
  - beq: 3 cycles.
- Each MemReady wait cycle adds one cycle.
- Reset asserted mid-MEMWRITE drops MemWrite in the same cycle (asynchronous gating). The FSM restarts at FETCH.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- With the macro defined:
  - An unknown op in DECODE goes to TRAP.
  - Extra output port IllegalInstr (1 bit, reset 0) is driven high in TRAP.
  - TRAP holds with all write enables 0 until reset.
- Without the macro: unknown op returns to FETCH (NOP behaviour) and the port is absent.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - opcode constants;
  - state encoding (11 states plus TRAP);
  - ImmSrc encodings;
  - ALUOp encodings;
  - ALUControl encodings;
  - ResultSrc, ALUSrcA and ALUSrcB select constants.
- One sub-module, alu_decoder, is combinational: inputs ALUOp, funct3, op[5], funct7b5; output ALUControl.

Test Plan:
- add (op=0110011, funct3=000, funct7b5=0), MemReady=1 -> FETCH, DECODE, EXECUTER, ALUWB; ALUControl=000 in EXECUTER; RegWrite=1 only in cycle 4; ImmSrc=00.
- lw (0000011) with MemReady=0 for 2 cycles in MEMREAD -> FSM holds in MEMREAD; RegWrite=1 with ResultSrc=01 exactly once; 7 cycles total.
- sw (0100011) -> ImmSrc=01; MemWrite=1 with AdrSrc=1 in MEMWRITE; then reset pulsed during MEMWRITE -> MemWrite=0 immediately and the FSM is in FETCH.
- beq (1100011): Zero=1 in the BEQ cycle -> PCWrite=1 and ALUControl=001; repeat with Zero=0 -> PCWrite=0. ImmSrc=10 in both runs.
- jal (1101111) -> ImmSrc=11; PCWrite=1 in JAL; RegWrite=1 in the following ALUWB; back in FETCH after 4 cycles.
- op=1111111 -> returns to FETCH with no write enables asserted. With MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: IllegalInstr=1 and the FSM stays in TRAP until reset.
